// File: rtl/dg_pkt_gen.sv
// Command-driven packet generator: header + deterministic payload toward one cache ingress port.
// Define DG_GEN_CHKSUM_EN to append an XOR checksum trailer beat carrying eop.
module dg_pkt_gen #(
    parameter logic [3:0]  PORT_ID = 4'd0,
    parameter int unsigned IFG     = 2,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        i_da,
    input  logic [2:0]        i_prior,
    input  logic [9:0]        i_len,
    input  logic              i_vld,
    output logic              o_dg_ready,
    input  logic              i_out_rdy,
    output logic              o_vld,
    output logic              o_sop,
    output logic              o_eop,
    output logic [DATA_W-1:0] o_data,
    output logic [15:0]       o_drop_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_HEAD, S_PAY, S_TRAIL, S_GAP} state_t;

    localparam int unsigned GAP_LAST_I = (IFG == 0) ? 0 : IFG - 1;
    localparam logic [3:0]  GAP_LAST   = GAP_LAST_I[3:0];
    localparam state_t      S_POST     = (IFG == 0) ? S_IDLE : S_GAP;

    state_t             r_state;
    state_t             w_nstate;
    logic [3:0]         r_da;
    logic [9:0]         r_len;
    logic [9:0]         r_idx;
    logic [7:0]         r_seq;
    logic [3:0]         r_gap;
    logic               r_vld;
    logic               r_sop;
    logic               r_eop;
    logic [DATA_W-1:0]  r_data;
    logic [15:0]        r_drop;

    logic               w_xfer;
    logic               w_accept;
    logic               w_drop;
    logic               w_last;
    logic [9:0]         w_idx_inc;
    logic [DATA_W-1:0]  w_hdr;

    assign o_dg_ready = (r_state == S_IDLE);
    assign o_vld      = r_vld;
    assign o_sop      = r_sop;
    assign o_eop      = r_eop;
    assign o_data     = r_data;
    assign o_drop_cnt = r_drop;

    assign w_xfer    = r_vld & i_out_rdy;
    assign w_accept  = i_vld & (r_state == S_IDLE) & (i_len != '0);
    assign w_drop    = i_vld & ((r_state != S_IDLE) | (i_len == '0));
    assign w_last    = (r_idx == r_len - 10'd1);
    assign w_idx_inc = r_idx + 10'd1;
    assign w_hdr     = {3'b000, PORT_ID, r_seq, i_len, i_prior, i_da};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_nstate = S_HEAD;
            S_HEAD:  if (w_xfer) w_nstate = S_PAY;
`ifdef DG_GEN_CHKSUM_EN
            S_PAY:   if (w_xfer && w_last) w_nstate = S_TRAIL;
`else
            S_PAY:   if (w_xfer && w_last) w_nstate = S_POST;
`endif
            S_TRAIL: if (w_xfer) w_nstate = S_POST;
            S_GAP:   if (r_gap == GAP_LAST) w_nstate = S_IDLE;
            default: w_nstate = S_IDLE;
        endcase
    end

`ifdef DG_GEN_CHKSUM_EN
    // Running XOR of every beat already transferred; the trailer folds in the last payload word.
    logic [DATA_W-1:0] r_csum;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           r_csum <= '0;
        else if (r_state == S_HEAD && w_xfer) r_csum <= r_data;
        else if (r_state == S_PAY && w_xfer)  r_csum <= r_csum ^ r_data;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_da   <= '0;
            r_len  <= '0;
            r_idx  <= '0;
            r_seq  <= '0;
            r_gap  <= '0;
            r_vld  <= 1'b0;
            r_sop  <= 1'b0;
            r_eop  <= 1'b0;
            r_data <= '0;
            r_drop <= '0;
        end else begin
            if (w_drop && r_drop != '1) r_drop <= r_drop + 16'd1;
            if (w_xfer && r_eop)        r_seq  <= r_seq + 8'd1;
            r_gap <= (r_state == S_GAP) ? r_gap + 4'd1 : '0;

            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_da   <= i_da;
                    r_len  <= i_len;
                    r_idx  <= '0;
                    r_vld  <= 1'b1;
                    r_sop  <= 1'b1;
                    r_eop  <= 1'b0;
                    r_data <= w_hdr;
                end
                S_HEAD: if (w_xfer) begin
                    r_sop  <= 1'b0;
                    r_data <= {PORT_ID, r_da, r_seq, 16'h0000};
`ifdef DG_GEN_CHKSUM_EN
                    r_eop  <= 1'b0;
`else
                    r_eop  <= (r_len == 10'd1);
`endif
                end
                S_PAY: if (w_xfer) begin
                    if (w_last) begin
`ifdef DG_GEN_CHKSUM_EN
                        r_data <= r_csum ^ r_data;
                        r_eop  <= 1'b1;
`else
                        r_vld  <= 1'b0;
                        r_eop  <= 1'b0;
                        r_data <= '0;
`endif
                    end else begin
                        r_idx  <= w_idx_inc;
                        r_data <= {PORT_ID, r_da, r_seq, 6'b000000, w_idx_inc};
`ifdef DG_GEN_CHKSUM_EN
                        r_eop  <= 1'b0;
`else
                        r_eop  <= (w_idx_inc == r_len - 10'd1);
`endif
                    end
                end
                S_TRAIL: if (w_xfer) begin
                    r_vld  <= 1'b0;
                    r_eop  <= 1'b0;
                    r_data <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dg_pkt_gen.sv
// Directed self-checking bench for dg_pkt_gen (PORT_ID=0, IFG=2).
module tb_dg_pkt_gen;

    localparam int IFG = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  i_da;
    logic [2:0]  i_prior;
    logic [9:0]  i_len;
    logic        i_vld;
    logic        o_dg_ready;
    logic        i_out_rdy;
    logic        o_vld;
    logic        o_sop;
    logic        o_eop;
    logic [31:0] o_data;
    logic [15:0] o_drop_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    dg_pkt_gen #(.PORT_ID(4'd0), .IFG(IFG), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_da(i_da), .i_prior(i_prior), .i_len(i_len), .i_vld(i_vld),
        .o_dg_ready(o_dg_ready), .i_out_rdy(i_out_rdy),
        .o_vld(o_vld), .o_sop(o_sop), .o_eop(o_eop),
        .o_data(o_data), .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [3:0] da, input logic [2:0] pr,
                                        input logic [9:0] len, input logic [7:0] seq);
        return {3'b000, 4'h0, seq, len, pr, da};
    endfunction

    function automatic logic [31:0] pay(input logic [3:0] da, input logic [7:0] seq, input int k);
        logic [15:0] kk;
        kk = 16'(k);
        return {4'h0, da, seq, kk};
    endfunction

    // Issues one command from IDLE and checks every beat plus the gap; optional stall / stray pulse.
    task automatic run_pkt(input logic [3:0] da, input logic [2:0] pr, input logic [9:0] len,
                           input logic [7:0] seq, input int stall_k, input int stall_n,
                           input int inj_k);
        logic [31:0] csum;
        logic [31:0] w;
        i_da = da; i_prior = pr; i_len = len; i_vld = 1'b1; i_out_rdy = 1'b1;
        @(negedge clk);
        i_vld = 1'b0;
        csum = hdr(da, pr, len, seq);
        chk("hdr_vld", {31'b0, o_vld}, 32'd1);
        chk("hdr_sop", {31'b0, o_sop}, 32'd1);
        chk("hdr_data", o_data, csum);
        chk("hdr_ready", {31'b0, o_dg_ready}, 32'd0);
        @(negedge clk);
        for (int k = 0; k < int'(len); k++) begin
            w = pay(da, seq, k);
            csum = csum ^ w;
            chk("pay_data", o_data, w);
            chk("pay_sop", {31'b0, o_sop}, 32'd0);
`ifdef DG_GEN_CHKSUM_EN
            chk("pay_eop", {31'b0, o_eop}, 32'd0);
`else
            chk("pay_eop", {31'b0, o_eop}, (k == int'(len) - 1) ? 32'd1 : 32'd0);
`endif
            if (k == inj_k) begin
                i_vld = 1'b1; i_da = 4'd5; i_len = 10'd4;
            end
            if (k == stall_k) begin
                i_out_rdy = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    chk("stall_vld", {31'b0, o_vld}, 32'd1);
                    chk("stall_data", o_data, w);
                end
                i_out_rdy = 1'b1;
            end
            @(negedge clk);
            i_vld = 1'b0; i_da = da; i_len = len;
        end
`ifdef DG_GEN_CHKSUM_EN
        chk("trl_data", o_data, csum);
        chk("trl_eop", {31'b0, o_eop}, 32'd1);
        @(negedge clk);
`endif
        for (int g = 0; g < IFG; g++) begin
            chk("gap_vld", {31'b0, o_vld}, 32'd0);
            chk("gap_ready", {31'b0, o_dg_ready}, 32'd0);
            @(negedge clk);
        end
        chk("post_ready", {31'b0, o_dg_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; i_da = '0; i_prior = '0; i_len = '0; i_vld = 1'b0; i_out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_ready", {31'b0, o_dg_ready}, 32'd1);
        chk("rst_vld", {31'b0, o_vld}, 32'd0);
        chk("rst_sop", {31'b0, o_sop}, 32'd0);
        chk("rst_eop", {31'b0, o_eop}, 32'd0);
        chk("rst_data", o_data, 32'h0);
        chk("rst_drop", {16'b0, o_drop_cnt}, 32'd0);

        // Scenario 1: hand-computed beats, da=3 prior=2 len=4 seq=0
        i_da = 4'd3; i_prior = 3'd2; i_len = 10'd4; i_vld = 1'b1;
        @(negedge clk);
        i_vld = 1'b0;
        chk("s1_hdr", o_data, 32'h0000_0223);
        chk("s1_sop", {31'b0, o_sop}, 32'd1);
        chk("s1_ready_t1", {31'b0, o_dg_ready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("s1_pay", o_data, 32'h0300_0000 + 32'(k));
`ifdef DG_GEN_CHKSUM_EN
            chk("s1_eop", {31'b0, o_eop}, 32'd0);
`else
            chk("s1_eop", {31'b0, o_eop}, (k == 3) ? 32'd1 : 32'd0);
`endif
            chk("s1_ready_pay", {31'b0, o_dg_ready}, 32'd0);
        end
`ifdef DG_GEN_CHKSUM_EN
        @(negedge clk);
        chk("s1_trl", o_data, 32'h0000_0223);
        chk("s1_trl_eop", {31'b0, o_eop}, 32'd1);
`endif
        @(negedge clk);
        chk("s1_gap0_vld", {31'b0, o_vld}, 32'd0);
        chk("s1_gap0_ready", {31'b0, o_dg_ready}, 32'd0);
        @(negedge clk);
        chk("s1_gap1_ready", {31'b0, o_dg_ready}, 32'd0);
        @(negedge clk);
        chk("s1_ready_back", {31'b0, o_dg_ready}, 32'd1);

        // Scenario 2: 3-cycle stall on payload word 1, seq=1
        run_pkt(4'd3, 3'd2, 10'd4, 8'd1, 1, 3, -1);
        chk("s2_drop", {16'b0, o_drop_cnt}, 32'd0);

        // Scenario 3: len==0 command is dropped
        i_len = 10'd0; i_vld = 1'b1;
        @(negedge clk);
        i_vld = 1'b0;
        chk("s3_vld", {31'b0, o_vld}, 32'd0);
        chk("s3_ready", {31'b0, o_dg_ready}, 32'd1);
        chk("s3_drop", {16'b0, o_drop_cnt}, 32'd1);
        @(negedge clk);
        chk("s3_vld2", {31'b0, o_vld}, 32'd0);

        // Scenario 4: stray command during payload is ignored; seq unchanged by the drop (2)
        run_pkt(4'd3, 3'd2, 10'd4, 8'd2, -1, 0, 1);
        chk("s4_drop", {16'b0, o_drop_cnt}, 32'd2);

        // Scenario 6: async reset mid-payload
        i_da = 4'd3; i_prior = 3'd2; i_len = 10'd4; i_vld = 1'b1;
        @(negedge clk);
        i_vld = 1'b0;
        chk("s6_hdr", o_data, 32'h0006_0223);
        repeat (2) @(negedge clk);
        chk("s6_pay1", o_data, 32'h0303_0001);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_vld", {31'b0, o_vld}, 32'd0);
        chk("s6_sop", {31'b0, o_sop}, 32'd0);
        chk("s6_eop", {31'b0, o_eop}, 32'd0);
        chk("s6_ready", {31'b0, o_dg_ready}, 32'd1);
        chk("s6_drop", {16'b0, o_drop_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("s6_post_vld", {31'b0, o_vld}, 32'd0);
        chk("s6_post_ready", {31'b0, o_dg_ready}, 32'd1);

        // Scenario 5: 257 len=1 packets, seq starts at 0 after reset and wraps
        for (int p = 0; p < 256; p++)
            run_pkt(4'd3, 3'd2, 10'd1, 8'(p), -1, 0, -1);
        i_da = 4'd3; i_prior = 3'd2; i_len = 10'd1; i_vld = 1'b1;
        @(negedge clk);
        i_vld = 1'b0;
        chk("s5_wrap_hdr", o_data, 32'h0000_00A3);
        @(negedge clk);
        chk("s5_wrap_pay", o_data, 32'h0300_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
